pipe_stage_buf: RTL

Parametrised elastic pipeline stage register for the CPU core. It is the successor to the fixed-field stage registers between EX/MEM and neighbouring stages. It carries a generic control field and a data payload under a valid/ready handshake, with a two-entry skid buffer, synchronous flush, and bubble masking of control bits. It sits between any two pipeline stages, so the upstream stage never needs a combinational path from downstream stall to its own enable.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_perf_cnt.sv | 20 ++
 rtl/pipe_stage_buf.sv | 118 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage buffer.
package pipe_pkg;

  // Occupancy of the stage: no entries, head only, head plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  localparam int unsigned PERF_CNT_W = 32;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter, cleared only by the asynchronous active-low reset.
module pipe_perf_cnt
  import pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  output logic [PERF_CNT_W-1:0] count
);

  // Count events, holding at all-ones once saturated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + PERF_CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: head register M plus skid register S under a
// valid/ready handshake, with synchronous flush and bubble-masked control.
// Optional stall counter enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 69
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [DATA_W-1:0]     out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_stall_cnt
`endif
);

  stage_state_e      state, next_state;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic [DATA_W-1:0] m_data, s_data;
  logic              in_fire, out_fire;
  logic              load_m_in, load_m_s, load_s;

  assign in_fire   = in_valid & in_ready;
  assign out_valid = (state != ST_EMPTY);
  assign out_fire  = out_valid & out_ready;
  assign out_ctrl  = out_valid ? m_ctrl : '0;
  assign out_data  = m_data;

  // Next-state and register-load decode; flush overrides the occupancy only.
  always_comb begin
    next_state = state;
    load_m_in  = 1'b0;
    load_m_s   = 1'b0;
    load_s     = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          load_m_in  = 1'b1;
          next_state = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          load_m_in = 1'b1;
        end else if (in_fire) begin
          load_s     = 1'b1;
          next_state = ST_TWO;
        end else if (out_fire) begin
          next_state = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_fire) begin
          load_m_s   = 1'b1;
          next_state = ST_ONE;
        end
      end
      default: next_state = ST_EMPTY;
    endcase
    if (flush) begin
      next_state = ST_EMPTY;
    end
  end

  // State register; in_ready is registered from next_state so upstream never
  // sees a combinational path from out_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state != ST_TWO);
    end
  end

  // Head and skid storage; contents after a flush are irrelevant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ctrl <= '0;
      m_data <= '0;
      s_ctrl <= '0;
      s_data <= '0;
    end else begin
      if (load_m_in) begin
        m_ctrl <= in_ctrl;
        m_data <= in_data;
      end else if (load_m_s) begin
        m_ctrl <= s_ctrl;
        m_data <= s_data;
      end
      if (load_s) begin
        s_ctrl <= in_ctrl;
        s_data <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_perf_cnt u_perf_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid & ~out_ready),
    .count (perf_stall_cnt)
  );
`endif

endmodule
